// File: rtl/cpu_pkg.sv
// Shared types, encodings and the instruction classifier for the multi-cycle core.
// The classifier is a pure function so the FSM only has to sequence its result.
package cpu_pkg;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_t;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_t;

    typedef enum logic [1:0] {
        TRAP_NONE, TRAP_ILLEGAL, TRAP_IMEM_TIMEOUT, TRAP_DMEM_TIMEOUT
    } trap_cause_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic    legal;
        alu_op_t alu_op;
        logic    alu_src;
        wb_sel_t wb_sel;
        logic    writes;
        logic    is_branch;
        logic    is_mem;
        logic    is_store;
    } dec_t;

    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic dec_t decode(input logic [31:0] ir, input logic rv64);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3        = ir[14:12];
        f7        = ir[31:25];
        d         = '0;
        d.legal   = 1'b1;
        d.writes  = 1'b1;
        d.alu_op  = ALU_ADD;
        d.wb_sel  = WB_ALU;
        case (ir[6:0])
            OPC_LUI:   begin d.wb_sel = WB_IMM; d.alu_src = 1'b1; end
            OPC_AUIPC: d.alu_src = 1'b1;
            OPC_JAL:   d.wb_sel = WB_PC4;
            OPC_JALR:  begin d.wb_sel = WB_PC4; d.alu_src = 1'b1; d.legal = (f3 == 3'b000); end
            OPC_BRANCH: begin
                d.alu_op = ALU_SUB; d.is_branch = 1'b1; d.writes = 1'b0;
                d.legal  = (f3[2:1] != 2'b01);
            end
            OPC_LOAD: begin
                d.alu_src = 1'b1; d.wb_sel = WB_MEM; d.is_mem = 1'b1;
                d.legal   = (f3 != 3'b011) && (f3[2:1] != 2'b11);
            end
            OPC_STORE: begin
                d.alu_src = 1'b1; d.is_mem = 1'b1; d.is_store = 1'b1; d.writes = 1'b0;
                d.legal   = !f3[2] && (f3[1:0] != 2'b11);
            end
            OPC_OP_IMM: begin
                d.alu_src = 1'b1;
                d.alu_op  = alu_from_f3(f3, ir[30] && (f3 == F3_SR));
                // shamt bit 5 only exists on RV64
                if (f3 == F3_SLL)
                    d.legal = (ir[31:26] == 6'd0) && (rv64 || !ir[25]);
                else if (f3 == F3_SR)
                    d.legal = !ir[31] && (ir[29:26] == 4'd0) && (rv64 || !ir[25]);
            end
            OPC_OP: begin
                d.alu_op = alu_from_f3(f3, ir[30]);
                d.legal  = (f7 == 7'd0) ||
                           ((f7 == 7'b0100000) && ((f3 == F3_ADD) || (f3 == F3_SR)));
            end
            default: begin d.legal = 1'b0; d.writes = 1'b0; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for every RV32I format, sign-extended to XLEN.
// Shift-immediates yield the zero-extended shamt instead of the I-type field.
module imm_gen
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ir,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;
    logic [5:0]  shamt;
    logic        is_shift;

    always_comb begin
        imm32 = '0;
        case (ir[6:0])
            OPC_LUI, OPC_AUIPC: imm32 = {ir[31:12], 12'b0};
            OPC_JAL:    imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            OPC_BRANCH: imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OPC_STORE:  imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            default:    imm32 = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    assign is_shift = (ir[6:0] == OPC_OP_IMM) && ((ir[14:12] == F3_SLL) || (ir[14:12] == F3_SR));
    assign shamt    = (XLEN == 64) ? ir[25:20] : {1'b0, ir[24:20]};
    assign imm      = is_shift ? XLEN'(shamt) : XLEN'($signed(imm32));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: fetch/decode/execute/mem/writeback with req/ack memory
// handshakes, bounded ack waits and a sticky trap on illegal ops or timeouts.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       instr_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [1:0]        dmem_size_o,
    output logic              dmem_unsigned_o,
    input  logic              dmem_ack_i,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [4:0]        rd_o,
    output logic [XLEN-1:0]   imm_o,
    output alu_op_t           alu_op_o,
    output logic              alu_src_o,
    output logic              branch_o,
    output logic [2:0]        funct3_o,
    output wb_sel_t           wb_sel_o,
    output logic              reg_write_o,
    output logic              pc_en_o,
    output logic              trap_o,
    output trap_cause_t       trap_cause_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state;
    logic [31:0]       ir;
    logic [CNT_W-1:0]  wait_cnt;
    logic              wb_en_q, mem_q, store_q, pc_strobe;
    logic              timed_out, store_done;
    logic [XLEN-1:0]   imm_w;
    dec_t              dec;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (.ir(ir), .imm(imm_w));

    assign dec       = decode(ir, XLEN == 64);
    assign timed_out = (TIMEOUT_CYCLES > 0) && (wait_cnt == LAST_WAIT);

    // A store retires in the ack cycle itself, so its PC strobe bypasses the register
    // to let the very next fetch see the updated PC.
    assign store_done = !rst && (state == S_MEM) && dmem_req_o && dmem_ack_i && dmem_we_o;
    assign pc_en_o    = pc_strobe | store_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_FETCH;
            ir              <= NOP;
            wait_cnt        <= '0;
            imem_req_o      <= 1'b0;
            dmem_req_o      <= 1'b0;
            dmem_we_o       <= 1'b0;
            dmem_size_o     <= 2'd0;
            dmem_unsigned_o <= 1'b0;
            rs1_o           <= '0;
            rs2_o           <= '0;
            rd_o            <= '0;
            imm_o           <= '0;
            alu_op_o        <= ALU_ADD;
            alu_src_o       <= 1'b0;
            branch_o        <= 1'b0;
            funct3_o        <= '0;
            wb_sel_o        <= WB_ALU;
            reg_write_o     <= 1'b0;
            pc_strobe       <= 1'b0;
            trap_o          <= 1'b0;
            trap_cause_o    <= TRAP_NONE;
            wb_en_q         <= 1'b0;
            mem_q           <= 1'b0;
            store_q         <= 1'b0;
        end else begin
            wait_cnt    <= '0;
            reg_write_o <= 1'b0;
            pc_strobe   <= 1'b0;
            branch_o    <= 1'b0;
            case (state)
                S_FETCH: begin
                    // request is raised one cycle after reset; an ack without it is ignored
                    if (!imem_req_o) begin
                        imem_req_o <= 1'b1;
                    end else if (imem_ack_i) begin
                        ir         <= instr_i;
                        imem_req_o <= 1'b0;
                        state      <= S_DECODE;
                    end else if (timed_out) begin
                        imem_req_o   <= 1'b0;
                        trap_o       <= 1'b1;
                        trap_cause_o <= TRAP_IMEM_TIMEOUT;
                        state        <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    rs1_o     <= ir[19:15];
                    rs2_o     <= ir[24:20];
                    rd_o      <= ir[11:7];
                    funct3_o  <= ir[14:12];
                    imm_o     <= imm_w;
                    alu_op_o  <= dec.alu_op;
                    alu_src_o <= dec.alu_src;
                    wb_sel_o  <= dec.wb_sel;
                    wb_en_q   <= dec.writes && (ir[11:7] != 5'd0);
                    mem_q     <= dec.is_mem;
                    store_q   <= dec.is_store;
                    if (!dec.legal) begin
                        trap_o       <= 1'b1;
                        trap_cause_o <= TRAP_ILLEGAL;
                        state        <= S_TRAP;
                    end else begin
                        branch_o <= dec.is_branch;
                        state    <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (mem_q) begin
                        dmem_req_o      <= 1'b1;
                        dmem_we_o       <= store_q;
                        dmem_size_o     <= funct3_o[1:0];
                        dmem_unsigned_o <= funct3_o[2];
                        state           <= S_MEM;
                    end else begin
                        reg_write_o <= wb_en_q;
                        pc_strobe   <= 1'b1;
                        state       <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack_i) begin
                        dmem_req_o <= 1'b0;
                        if (dmem_we_o) begin
                            imem_req_o <= 1'b1;
                            state      <= S_FETCH;
                        end else begin
                            reg_write_o <= wb_en_q;
                            pc_strobe   <= 1'b1;
                            state       <= S_WB;
                        end
                    end else if (timed_out) begin
                        dmem_req_o   <= 1'b0;
                        trap_o       <= 1'b1;
                        trap_cause_o <= TRAP_DMEM_TIMEOUT;
                        state        <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    imem_req_o <= 1'b1;
                    state      <= S_FETCH;
                end
                default: state <= S_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: one RV32 instance and one RV64 instance, both with a 4-cycle ack timeout,
// fed the same instruction stream with per-instance zero/programmable-wait memory responders.
module tb_multicycle_control;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = NOP;
    logic        imem_ok = 1'b1;
    logic [7:0]  dlat = 8'd0;
    logic [7:0]  dcnt0 = 8'd0, dcnt1 = 8'd0;

    logic        imem_req0, imem_ack0, dmem_req0, dmem_we0, dmem_uns0, dmem_ack0;
    logic [1:0]  dmem_size0;
    logic [4:0]  rs1_0, rs2_0, rd_0;
    logic [31:0] imm0;
    alu_op_t     alu_op0;
    logic        alu_src0, branch0, reg_write0, pc_en0, trap0;
    logic [2:0]  funct3_0;
    wb_sel_t     wb_sel0;
    trap_cause_t cause0;

    logic        imem_req1, imem_ack1, dmem_req1, dmem_we1, dmem_uns1, dmem_ack1;
    logic [1:0]  dmem_size1;
    logic [4:0]  rs1_1, rs2_1, rd_1;
    logic [63:0] imm1;
    alu_op_t     alu_op1;
    logic        alu_src1, branch1, reg_write1, pc_en1, trap1;
    logic [2:0]  funct3_1;
    wb_sel_t     wb_sel1;
    trap_cause_t cause1;

    int n_chk = 0, n_err = 0;
    int rw_cyc, pc_cyc, br_cyc, tr_cyc, rw_n, pc_n, br_n, ireq_n, dreq_n, rw1_n;

    always #5 clk = ~clk;

    assign imem_ack0 = imem_req0 & imem_ok;
    assign imem_ack1 = imem_req1 & imem_ok;
    assign dmem_ack0 = dmem_req0 && (dcnt0 == dlat);
    assign dmem_ack1 = dmem_req1 && (dcnt1 == dlat);

    always @(posedge clk) begin
        dcnt0 <= dmem_req0 ? dcnt0 + 8'd1 : 8'd0;
        dcnt1 <= dmem_req1 ? dcnt1 + 8'd1 : 8'd0;
    end

    multicycle_control #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .imem_req_o(imem_req0), .imem_ack_i(imem_ack0), .instr_i(instr),
        .dmem_req_o(dmem_req0), .dmem_we_o(dmem_we0), .dmem_size_o(dmem_size0),
        .dmem_unsigned_o(dmem_uns0), .dmem_ack_i(dmem_ack0), .rs1_o(rs1_0), .rs2_o(rs2_0),
        .rd_o(rd_0), .imm_o(imm0), .alu_op_o(alu_op0), .alu_src_o(alu_src0), .branch_o(branch0),
        .funct3_o(funct3_0), .wb_sel_o(wb_sel0), .reg_write_o(reg_write0), .pc_en_o(pc_en0),
        .trap_o(trap0), .trap_cause_o(cause0));

    multicycle_control #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut1 (
        .clk(clk), .rst(rst), .imem_req_o(imem_req1), .imem_ack_i(imem_ack1), .instr_i(instr),
        .dmem_req_o(dmem_req1), .dmem_we_o(dmem_we1), .dmem_size_o(dmem_size1),
        .dmem_unsigned_o(dmem_uns1), .dmem_ack_i(dmem_ack1), .rs1_o(rs1_1), .rs2_o(rs2_1),
        .rd_o(rd_1), .imm_o(imm1), .alu_op_o(alu_op1), .alu_src_o(alu_src1), .branch_o(branch1),
        .funct3_o(funct3_1), .wb_sel_o(wb_sel1), .reg_write_o(reg_write1), .pc_en_o(pc_en1),
        .trap_o(trap1), .trap_cause_o(cause1));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reset both cores, then release and log events for ncyc cycles; cycle c is the
    // c-th rising edge after release, sampled on the following falling edge.
    task automatic run(input logic [31:0] ins, input logic iok, input logic [7:0] dl,
                       input int ncyc);
        instr = ins; imem_ok = iok; dlat = dl;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        rw_cyc = 0; pc_cyc = 0; br_cyc = 0; tr_cyc = 0;
        rw_n = 0; pc_n = 0; br_n = 0; ireq_n = 0; dreq_n = 0; rw1_n = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (reg_write0) begin rw_n++; if (rw_cyc == 0) rw_cyc = c; end
            if (pc_en0)     begin pc_n++; if (pc_cyc == 0) pc_cyc = c; end
            if (branch0)    begin br_n++; if (br_cyc == 0) br_cyc = c; end
            if (trap0 && tr_cyc == 0) tr_cyc = c;
            if (imem_req0)  ireq_n++;
            if (dmem_req0)  dreq_n++;
            if (reg_write1) rw1_n++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_imem_req", imem_req0, 0);
        check("rst_dmem_req", dmem_req0, 0);
        check("rst_strobes", {reg_write0, pc_en0, branch0}, 0);
        check("rst_trap", {trap0, cause0}, 0);

        // ADDI x1,x0,-5
        run(32'hFFB0_0093, 1'b1, 8'd0, 6);
        check("addi_imm", imm0, 64'hFFFF_FFFB);
        check("addi_alu_src", alu_src0, 1);
        check("addi_rd", rd_0, 1);
        check("addi_rw_cycle", rw_cyc, 4);
        check("addi_pc_cycle", pc_cyc, 4);
        check("addi_rw_count", rw_n, 1);
        check("addi64_imm", imm1, 64'hFFFF_FFFF_FFFF_FFFB);

        // LW x2,8(x1), ack on the 4th request cycle
        run(32'h0080_A103, 1'b1, 8'd3, 10);
        check("lw_dreq_cycles", dreq_n, 4);
        check("lw_size", dmem_size0, 2);
        check("lw_we", dmem_we0, 0);
        check("lw_wb_sel", wb_sel0, WB_MEM);
        check("lw_imm", imm0, 8);
        check("lw_rw_cycle", rw_cyc, 8);
        check("lw_no_trap", trap0, 0);

        // LHU x3,0(x1), zero wait
        run(32'h0000_D183, 1'b1, 8'd0, 7);
        check("lhu_size", dmem_size0, 1);
        check("lhu_unsigned", dmem_uns0, 1);
        check("lhu_rw_cycle", rw_cyc, 5);

        // SW x2,4(x1), zero wait: PC strobe in the MEM cycle
        run(32'h0020_A223, 1'b1, 8'd0, 6);
        check("sw_we", dmem_we0, 1);
        check("sw_imm", imm0, 4);
        check("sw_pc_cycle", pc_cyc, 4);
        check("sw_pc_count", pc_n, 1);
        check("sw_rw_count", rw_n, 0);

        // BEQ, imm -4
        run(32'hFE00_0EE3, 1'b1, 8'd0, 6);
        check("beq_branch_cycle", br_cyc, 3);
        check("beq_branch_count", br_n, 1);
        check("beq_imm", imm0, 64'hFFFF_FFFC);
        check("beq_alu_op", alu_op0, ALU_SUB);
        check("beq_rw_count", rw_n, 0);
        check("beq_pc_cycle", pc_cyc, 4);

        // ADDI x0,x0,1
        run(32'h0010_0013, 1'b1, 8'd0, 6);
        check("x0_pc_cycle", pc_cyc, 4);
        check("x0_rw_count", rw_n, 0);

        // SRAI x3,x1,3
        run(32'h4030_D193, 1'b1, 8'd0, 6);
        check("srai_imm", imm0, 3);
        check("srai_alu_op", alu_op0, ALU_SRA);

        // SLLI x1,x1,40: illegal on RV32, legal on RV64
        run(32'h0280_9093, 1'b1, 8'd0, 6);
        check("slli40_rv32_cause", cause0, TRAP_ILLEGAL);
        check("slli40_rv64_trap", trap1, 0);
        check("slli40_rv64_imm", imm1, 40);
        check("slli40_rv64_alu_op", alu_op1, ALU_SLL);
        check("slli40_rv64_rw_count", rw1_n, 1);

        // Unknown opcode
        run(32'h0000_007F, 1'b1, 8'd0, 10);
        check("illegal_trap_cycle", tr_cyc, 3);
        check("illegal_cause", cause0, TRAP_ILLEGAL);
        check("illegal_req_count", ireq_n, 1);
        check("illegal_strobes", pc_n + rw_n, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("trap_cleared", {trap0, cause0}, 0);
        rst = 1'b0;

        // Instruction memory never acks
        run(32'h0000_0013, 1'b0, 8'd0, 8);
        check("imem_to_req_cycles", ireq_n, 4);
        check("imem_to_trap_cycle", tr_cyc, 5);
        check("imem_to_cause", cause0, TRAP_IMEM_TIMEOUT);
        check("imem_to_cause_rv64", cause1, TRAP_IMEM_TIMEOUT);

        // Data memory never acks
        run(32'h0080_A103, 1'b1, 8'd255, 12);
        check("dmem_to_req_cycles", dreq_n, 4);
        check("dmem_to_trap_cycle", tr_cyc, 8);
        check("dmem_to_cause", cause0, TRAP_DMEM_TIMEOUT);
        check("dmem_to_rw_count", rw_n, 0);

        // Reset during a pending fetch drops the request next cycle
        run(32'h0000_0013, 1'b0, 8'd0, 2);
        check("midrst_req_before", imem_req0, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req_after", imem_req0, 0);
        check("midrst_strobes", {reg_write0, pc_en0}, 0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
